// File: rtl/display_pkg.sv
// Shared seven-segment types and the hex-to-segment lookup used by the digit scanner.
package display_pkg;

    typedef logic [6:0] seg7_t;

    // Active-high segment patterns, bit order g..a.
    localparam seg7_t SEG_OFF = 7'b0000000;

    localparam seg7_t HEX_SEG [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] nib,
    output seg7_t      seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/digit_scanner.sv
// Time-multiplexed N-digit seven-segment driver with per-frame snapshots,
// dead time between digits, per-digit blanking and output polarity control.
module digit_scanner
    import display_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 27_000_000,
    parameter int SCAN_HZ        = 500,
    parameter int N_DIGITS       = 3,
    parameter int BLANK_CYCLES   = 16,
    parameter bit AN_ACTIVE_LOW  = 1'b0,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   blank_mask,
    output logic [N_DIGITS-1:0]   an,
    output seg7_t                 seg,
    output logic                  dp_o,
    output logic                  frame_start
);

    localparam int DWELL = CLK_FREQ_HZ / (2 * SCAN_HZ);
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0]    CNT_SHOW = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]    IDX_TOP  = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? '1 : '0;
    localparam seg7_t               SEG_INV  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    generate
        if (N_DIGITS < 2) begin : g_bad_ndigits
            $error("digit_scanner: N_DIGITS must be at least 2");
        end
        if (BLANK_CYCLES >= DWELL) begin : g_bad_blank
            $error("digit_scanner: BLANK_CYCLES must be smaller than the dwell length");
        end
    endgenerate

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [4*N_DIGITS-1:0] snap_digits;
    logic [N_DIGITS-1:0]   snap_dp;
    logic [N_DIGITS-1:0]   snap_blank;

    logic                  capture;
    logic [4*N_DIGITS-1:0] view_digits;
    logic [N_DIGITS-1:0]   view_dp;
    logic [N_DIGITS-1:0]   view_blank;
    logic [3:0]            nib;
    seg7_t                 dec_seg;
    logic                  show;
    logic [N_DIGITS-1:0]   sel;

    assign capture     = en && !rst && (cnt == '0) && (idx == IDX_TOP);
    assign frame_start = capture;

    // On the capture cycle the registers still hold the old frame, so the
    // first digit must be rendered straight from the inputs being captured.
    assign view_digits = capture ? digits     : snap_digits;
    assign view_dp     = capture ? dp         : snap_dp;
    assign view_blank  = capture ? blank_mask : snap_blank;

    assign nib  = view_digits[{idx, 2'b00} +: 4];
    assign show = (cnt >= CNT_SHOW) && !view_blank[idx];
    assign sel  = {{(N_DIGITS-1){1'b0}}, 1'b1} << idx;

    seg7_decode u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= IDX_TOP;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_blank  <= '0;
            an          <= AN_OFF;
            seg         <= SEG_OFF ^ SEG_INV;
            dp_o        <= SEG_ACTIVE_LOW;
        end else if (!en) begin
            cnt  <= '0;
            idx  <= IDX_TOP;
            an   <= AN_OFF;
            seg  <= SEG_OFF ^ SEG_INV;
            dp_o <= SEG_ACTIVE_LOW;
        end else begin
            if (capture) begin
                snap_digits <= digits;
                snap_dp     <= dp;
                snap_blank  <= blank_mask;
            end
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == '0) ? IDX_TOP : idx - 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            an   <= (show ? sel : '0) ^ AN_OFF;
            seg  <= (show ? dec_seg : SEG_OFF) ^ SEG_INV;
            dp_o <= (show && view_dp[idx]) ^ SEG_ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_digit_scanner.sv
// Directed bench for digit_scanner: DWELL=5, three digits, two blank cycles,
// plus active-low and zero-dead-time variants sharing the same stimulus.
module tb_digit_scanner;

    logic        clk;
    logic        rst;
    logic        en;
    logic [11:0] digits;
    logic [2:0]  dp;
    logic [2:0]  blank_mask;

    logic [2:0]  an,    an_al,    an_b0;
    logic [6:0]  seg,   seg_al,   seg_b0;
    logic        dp_o,  dp_o_al,  dp_o_b0;
    logic        fs,    fs_al,    fs_b0;

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;

    localparam logic [6:0] SEGS [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    digit_scanner #(.CLK_FREQ_HZ(1000), .SCAN_HZ(100), .N_DIGITS(3), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .en(en), .digits(digits), .dp(dp), .blank_mask(blank_mask),
        .an(an), .seg(seg), .dp_o(dp_o), .frame_start(fs));

    digit_scanner #(.CLK_FREQ_HZ(1000), .SCAN_HZ(100), .N_DIGITS(3), .BLANK_CYCLES(2),
                    .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst(rst), .en(en), .digits(digits), .dp(dp), .blank_mask(blank_mask),
        .an(an_al), .seg(seg_al), .dp_o(dp_o_al), .frame_start(fs_al));

    digit_scanner #(.CLK_FREQ_HZ(1000), .SCAN_HZ(100), .N_DIGITS(3), .BLANK_CYCLES(0)) dut_b0 (
        .clk(clk), .rst(rst), .en(en), .digits(digits), .dp(dp), .blank_mask(blank_mask),
        .an(an_b0), .seg(seg_b0), .dp_o(dp_o_b0), .frame_start(fs_b0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_on) begin
            checks++;
            assert ($onehot0(an) && $onehot0(~an_al) && $onehot0(an_b0))
            else begin
                errors++;
                $display("FAIL onehot0 an=%b an_al=%b an_b0=%b", an, an_al, an_b0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then enable with the given value; state is cnt=0, idx=2 on return.
    task automatic start(input logic [11:0] d);
        rst = 1'b1;
        en  = 1'b0;
        tick();
        tick();
        digits = d;
        rst    = 1'b0;
        en     = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; digits = 12'h1A8; dp = 3'b111; blank_mask = 3'b000;
        tick();
        tick();
        mon_on = 1'b1;
        checks++; if (an !== 3'b000)        begin errors++; $display("FAIL reset_an got %b exp 000", an); end
        checks++; if (seg !== 7'b0000000)   begin errors++; $display("FAIL reset_seg got %b exp 0000000", seg); end
        checks++; if (dp_o !== 1'b0)        begin errors++; $display("FAIL reset_dp got %b exp 0", dp_o); end
        checks++; if (fs !== 1'b0)          begin errors++; $display("FAIL reset_fs got %b exp 0", fs); end
        checks++; if (an_al !== 3'b111)     begin errors++; $display("FAIL reset_an_al got %b exp 111", an_al); end
        checks++; if (seg_al !== 7'b1111111) begin errors++; $display("FAIL reset_seg_al got %b exp 1111111", seg_al); end
        checks++; if (an_b0 !== 3'b000)     begin errors++; $display("FAIL reset_an_b0 got %b exp 000", an_b0); end
        dp = 3'b000;
    endtask

    // Two frames; the value changes to 345 at cnt=2 of digit 1 in the first frame.
    task automatic test_scan_snapshot();
        logic [11:0] dv;
        logic [2:0]  ea;
        logic [6:0]  es;
        int q, c, ix;
        start(12'h1A8);
        checks++; if (fs !== 1'b1) begin errors++; $display("FAIL scan_fs_first got %b exp 1", fs); end
        for (int j = 1; j <= 30; j++) begin
            tick();
            q  = j - 1;
            c  = q % 5;
            ix = 2 - (q / 5) % 3;
            dv = (q < 15) ? 12'h1A8 : 12'h345;
            ea = (c >= 2) ? (3'b001 << ix) : 3'b000;
            es = (c >= 2) ? SEGS[dv[ix*4 +: 4]] : 7'b0000000;
            checks++; if (an !== ea)  begin errors++; $display("FAIL scan_an j=%0d got %b exp %b", j, an, ea); end
            checks++; if (seg !== es) begin errors++; $display("FAIL scan_seg j=%0d got %b exp %b", j, seg, es); end
            checks++; if (fs !== (j % 15 == 0)) begin errors++; $display("FAIL scan_fs j=%0d got %b", j, fs); end
            if (j == 7) digits = 12'h345;
        end
    endtask

    task automatic test_blank_dp();
        logic [2:0] ea;
        logic       ed;
        int q, c, ix;
        blank_mask = 3'b100;
        dp         = 3'b010;
        start(12'h1A8);
        for (int j = 1; j <= 15; j++) begin
            tick();
            q  = j - 1;
            c  = q % 5;
            ix = 2 - (q / 5) % 3;
            ea = (c >= 2 && ix != 2) ? (3'b001 << ix) : 3'b000;
            ed = (c >= 2 && ix == 1);
            checks++; if (an !== ea)   begin errors++; $display("FAIL blank_an j=%0d got %b exp %b", j, an, ea); end
            checks++; if (dp_o !== ed) begin errors++; $display("FAIL blank_dp j=%0d got %b exp %b", j, dp_o, ed); end
        end
        blank_mask = 3'b000;
        dp         = 3'b000;
    endtask

    task automatic test_active_low();
        logic [2:0] ea;
        logic [6:0] es;
        int q, c, ix;
        start(12'h000);
        for (int j = 1; j <= 15; j++) begin
            tick();
            q  = j - 1;
            c  = q % 5;
            ix = 2 - (q / 5) % 3;
            ea = (c >= 2) ? ~(3'b001 << ix) : 3'b111;
            es = (c >= 2) ? 7'b1000000 : 7'b1111111;
            checks++; if (an_al !== ea)    begin errors++; $display("FAIL al_an j=%0d got %b exp %b", j, an_al, ea); end
            checks++; if (seg_al !== es)   begin errors++; $display("FAIL al_seg j=%0d got %b exp %b", j, seg_al, es); end
            checks++; if (dp_o_al !== 1'b1) begin errors++; $display("FAIL al_dp j=%0d got %b exp 1", j, dp_o_al); end
        end
    endtask

    task automatic test_rst_en_restart();
        logic [11:0] dv;
        logic [2:0]  ea;
        logic [6:0]  es;
        int q, c, ix;
        start(12'h1A8);
        for (int j = 1; j <= 8; j++) tick();
        checks++; if (an !== 3'b010) begin errors++; $display("FAIL pre_rst_an got %b exp 010", an); end
        rst = 1'b1;
        tick();
        checks++; if (an !== 3'b000)      begin errors++; $display("FAIL midrst_an got %b exp 000", an); end
        checks++; if (seg !== 7'b0000000) begin errors++; $display("FAIL midrst_seg got %b exp 0000000", seg); end
        checks++; if (fs !== 1'b0)        begin errors++; $display("FAIL midrst_fs got %b exp 0", fs); end
        for (int phase = 0; phase < 2; phase++) begin
            dv     = (phase == 0) ? 12'h345 : 12'h7C2;
            digits = dv;
            rst    = 1'b0;
            en     = 1'b1;
            #1;
            checks++; if (fs !== 1'b1) begin errors++; $display("FAIL restart_fs p=%0d got %b exp 1", phase, fs); end
            for (int j = 1; j <= 12; j++) begin
                tick();
                q  = j - 1;
                c  = q % 5;
                ix = 2 - (q / 5) % 3;
                ea = (c >= 2) ? (3'b001 << ix) : 3'b000;
                es = (c >= 2) ? SEGS[dv[ix*4 +: 4]] : 7'b0000000;
                checks++; if (an !== ea)  begin errors++; $display("FAIL restart_an p=%0d j=%0d got %b exp %b", phase, j, an, ea); end
                checks++; if (seg !== es) begin errors++; $display("FAIL restart_seg p=%0d j=%0d got %b exp %b", phase, j, seg, es); end
            end
            if (phase == 0) begin
                en = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    checks++; if (an !== 3'b000)      begin errors++; $display("FAIL endrop_an k=%0d got %b exp 000", k, an); end
                    checks++; if (seg !== 7'b0000000) begin errors++; $display("FAIL endrop_seg k=%0d got %b exp 0000000", k, seg); end
                    checks++; if (fs !== 1'b0)        begin errors++; $display("FAIL endrop_fs k=%0d got %b exp 0", k, fs); end
                end
            end
        end
    endtask

    task automatic test_no_blank();
        logic [2:0] ea;
        logic [6:0] es;
        logic [11:0] dv;
        int q, ix;
        dv = 12'h1A8;
        start(dv);
        for (int j = 1; j <= 15; j++) begin
            tick();
            q  = j - 1;
            ix = 2 - (q / 5) % 3;
            ea = 3'b001 << ix;
            es = SEGS[dv[ix*4 +: 4]];
            checks++; if (an_b0 !== ea)  begin errors++; $display("FAIL b0_an j=%0d got %b exp %b", j, an_b0, ea); end
            checks++; if (seg_b0 !== es) begin errors++; $display("FAIL b0_seg j=%0d got %b exp %b", j, seg_b0, es); end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; digits = '0; dp = '0; blank_mask = '0;
        test_reset();
        test_scan_snapshot();
        test_blank_dp();
        test_active_low();
        test_rst_en_restart();
        test_no_blank();
        mon_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
